// File: rtl/braille_cell_encoder.sv
// ASCII-to-Braille cell encoder with number-sign prefixing and timed dwell/gap presentation.
// Optional feature: define BRL_LETTER_SIGN_EN to emit a letter sign before a-j following digits.
module braille_cell_encoder #(
    parameter int DWELL = 25_000_000,
    parameter int GAP   = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [6:0] in_char,
    output logic       in_ready,
    output logic [5:0] dots,
    output logic       cell_valid,
    output logic       done,
    output logic       bad
);

    localparam int MAX_T = (DWELL > GAP) ? DWELL : GAP;
    localparam int CNT_W = $clog2(MAX_T + 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP - 1);

    localparam logic [5:0] NUM_SIGN = 6'b111100;
    localparam logic [5:0] LET_SIGN = 6'b110000;
    localparam logic [5:0] DOT3     = 6'b000100;
    localparam logic [5:0] DOT36    = 6'b100100;
    localparam logic [5:0] W_CELL   = 6'b111010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFIX,
        S_PGAP,
        S_CELL,
        S_CGAP
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [5:0]       dots_next;
    logic             cell_valid_next;
    logic             bad_next;
    logic             num_mode, num_mode_next;
    logic [5:0]       cell_pat, cell_pat_next;

    logic [6:0] lower_char;
    logic [6:0] letter_off;
    logic [6:0] digit_off;
    logic       is_letter;
    logic       is_digit;
    logic       is_space;
    logic       is_bad;
    logic [5:0] char_pat;
    logic       need_prefix;
    logic [5:0] prefix_pat;
    logic       accept;
    logic       cnt_zero;

    // Patterns for a..j; every other letter and digit is derived from these.
    function automatic logic [5:0] base_pattern(input logic [6:0] idx);
        logic [5:0] pat;
        case (idx)
            7'd0:    pat = 6'b000001;
            7'd1:    pat = 6'b000011;
            7'd2:    pat = 6'b001001;
            7'd3:    pat = 6'b011001;
            7'd4:    pat = 6'b010001;
            7'd5:    pat = 6'b001011;
            7'd6:    pat = 6'b011011;
            7'd7:    pat = 6'b010011;
            7'd8:    pat = 6'b001010;
            7'd9:    pat = 6'b011010;
            default: pat = 6'b000000;
        endcase
        return pat;
    endfunction

    assign accept   = in_valid && (state == S_IDLE);
    assign cnt_zero = (cnt == '0);
    assign in_ready = (state == S_IDLE);
    assign done     = (state == S_CGAP) && cnt_zero;

    always_comb begin
        lower_char = in_char;
        if (in_char >= 7'h41 && in_char <= 7'h5A) begin
            lower_char = in_char | 7'h20;
        end
        letter_off = lower_char - 7'h61;
        digit_off  = in_char - 7'h30;
        is_letter  = (lower_char >= 7'h61) && (lower_char <= 7'h7A);
        is_digit   = (in_char >= 7'h30) && (in_char <= 7'h39);
        is_space   = (in_char == 7'h20);
        is_bad     = !is_letter && !is_digit && !is_space;
    end

    // u, v, x, y, z reuse a..e with dots 3 and 6; w is the odd one out.
    always_comb begin
        char_pat = 6'b000000;
        if (is_letter) begin
            if (letter_off < 7'd10) begin
                char_pat = base_pattern(letter_off);
            end else if (letter_off < 7'd20) begin
                char_pat = base_pattern(letter_off - 7'd10) | DOT3;
            end else if (letter_off == 7'd22) begin
                char_pat = W_CELL;
            end else if (letter_off < 7'd22) begin
                char_pat = base_pattern(letter_off - 7'd20) | DOT36;
            end else begin
                char_pat = base_pattern(letter_off - 7'd21) | DOT36;
            end
        end else if (is_digit) begin
            if (digit_off == 7'd0) begin
                char_pat = base_pattern(7'd9);
            end else begin
                char_pat = base_pattern(digit_off - 7'd1);
            end
        end
    end

    always_comb begin
        need_prefix = 1'b0;
        prefix_pat  = NUM_SIGN;
        if (is_digit && !num_mode) begin
            need_prefix = 1'b1;
            prefix_pat  = NUM_SIGN;
        end
`ifdef BRL_LETTER_SIGN_EN
        if (is_letter && num_mode && (letter_off < 7'd10)) begin
            need_prefix = 1'b1;
            prefix_pat  = LET_SIGN;
        end
`else
        if (LET_SIGN == NUM_SIGN) begin
            prefix_pat = NUM_SIGN;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        dots_next       = dots;
        cell_valid_next = cell_valid;
        bad_next        = 1'b0;
        num_mode_next   = num_mode;
        cell_pat_next   = cell_pat;
        case (state)
            S_IDLE: begin
                dots_next       = 6'b000000;
                cell_valid_next = 1'b0;
                if (accept) begin
                    cell_pat_next   = char_pat;
                    bad_next        = is_bad;
                    cnt_next        = DWELL_LOAD;
                    cell_valid_next = 1'b1;
                    if (is_digit) begin
                        num_mode_next = 1'b1;
                    end else if (is_space || is_letter) begin
                        num_mode_next = 1'b0;
                    end
                    if (need_prefix) begin
                        state_next = S_PREFIX;
                        dots_next  = prefix_pat;
                    end else begin
                        state_next = S_CELL;
                        dots_next  = char_pat;
                    end
                end
            end
            S_PREFIX: begin
                if (cnt_zero) begin
                    state_next      = S_PGAP;
                    cnt_next        = GAP_LOAD;
                    dots_next       = 6'b000000;
                    cell_valid_next = 1'b0;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            S_PGAP: begin
                if (cnt_zero) begin
                    state_next      = S_CELL;
                    cnt_next        = DWELL_LOAD;
                    dots_next       = cell_pat;
                    cell_valid_next = 1'b1;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            S_CELL: begin
                if (cnt_zero) begin
                    state_next      = S_CGAP;
                    cnt_next        = GAP_LOAD;
                    dots_next       = 6'b000000;
                    cell_valid_next = 1'b0;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            S_CGAP: begin
                if (cnt_zero) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                state_next      = S_IDLE;
                dots_next       = 6'b000000;
                cell_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            dots       <= 6'b000000;
            cell_valid <= 1'b0;
            bad        <= 1'b0;
            num_mode   <= 1'b0;
            cell_pat   <= 6'b000000;
        end else begin
            cnt        <= cnt_next;
            dots       <= dots_next;
            cell_valid <= cell_valid_next;
            bad        <= bad_next;
            num_mode   <= num_mode_next;
            cell_pat   <= cell_pat_next;
        end
    end

endmodule

// File: tb/tb_braille_cell_encoder.sv
// Directed, table-driven bench for braille_cell_encoder with DWELL=4, GAP=2.
// Expected letter-sign cells follow BRL_LETTER_SIGN_EN as defined for the build.
module tb_braille_cell_encoder;

    localparam int DWELL    = 4;
    localparam int GAP      = 2;
    localparam int CELL_CYC = DWELL + GAP;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [6:0] in_char;
    logic       in_ready;
    logic [5:0] dots;
    logic       cell_valid;
    logic       done;
    logic       bad;
    logic [9:0] obs;

    int vectors;
    int miscompares;

    typedef struct {
        logic [6:0]      ch;
        int              ncells;
        logic [2:0][5:0] cells;
        bit              exp_bad;
        bit              noise;
    } vec_t;

    vec_t tbl[20];
    int   ntbl;

    braille_cell_encoder #(.DWELL(DWELL), .GAP(GAP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_char   (in_char),
        .in_ready  (in_ready),
        .dots      (dots),
        .cell_valid(cell_valid),
        .done      (done),
        .bad       (bad)
    );

    assign obs = {in_ready, bad, done, cell_valid, dots};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [6:0] ch, input int n, input logic [5:0] c0,
                                input logic [5:0] c1, input bit b, input bit nz);
        vec_t v;
        v.ch       = ch;
        v.ncells   = n;
        v.cells[0] = c0;
        v.cells[1] = c1;
        v.cells[2] = 6'b000000;
        v.exp_bad  = b;
        v.noise    = nz;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got {rdy,bad,done,cv,dots}=%b, want %b", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int         waits;
        int         total;
        int         ci;
        int         pos;
        logic [9:0] exp;
        waits = 0;
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL v%0d_ready_timeout: got in_ready=0, want 1", idx);
            return;
        end
        in_valid = 1'b1;
        in_char  = v.ch;
        @(posedge clk);
        total = v.ncells * CELL_CYC;
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            if (v.noise && k < total) begin
                in_valid = 1'($urandom_range(0, 1));
                in_char  = 7'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            ci  = (k - 1) / CELL_CYC;
            pos = (k - 1) % CELL_CYC;
            exp = {1'b0, (k == 1) && v.exp_bad, (ci == v.ncells - 1) && (pos == CELL_CYC - 1),
                   pos < DWELL, (pos < DWELL) ? v.cells[ci] : 6'b000000};
            checkOutput($sformatf("v%0d_'%c'_k%0d", idx, v.ch, k), obs, exp);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput($sformatf("v%0d_'%c'_idle", idx, v.ch), obs, 10'b1_0_0_0_000000);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_char     = 7'h00;

        ntbl = 0;
        tbl[ntbl++] = mk(7'h61, 1, 6'b000001, 6'b000000, 1'b0, 1'b0);  // a
        tbl[ntbl++] = mk(7'h35, 2, 6'b111100, 6'b010001, 1'b0, 1'b0);  // 5 with number sign
        tbl[ntbl++] = mk(7'h37, 1, 6'b011011, 6'b000000, 1'b0, 1'b0);  // 7 in number mode
        tbl[ntbl++] = mk(7'h20, 1, 6'b000000, 6'b000000, 1'b0, 1'b0);  // space
        tbl[ntbl++] = mk(7'h31, 2, 6'b111100, 6'b000001, 1'b0, 1'b0);  // 1
`ifdef BRL_LETTER_SIGN_EN
        tbl[ntbl++] = mk(7'h62, 2, 6'b110000, 6'b000011, 1'b0, 1'b0);  // b after digit
`else
        tbl[ntbl++] = mk(7'h62, 1, 6'b000011, 6'b000000, 1'b0, 1'b0);
`endif
        tbl[ntbl++] = mk(7'h5A, 1, 6'b110101, 6'b000000, 1'b0, 1'b0);  // Z
        tbl[ntbl++] = mk(7'h77, 1, 6'b111010, 6'b000000, 1'b0, 1'b0);  // w
        tbl[ntbl++] = mk(7'h4B, 1, 6'b000101, 6'b000000, 1'b0, 1'b0);  // K
        tbl[ntbl++] = mk(7'h75, 1, 6'b100101, 6'b000000, 1'b0, 1'b0);  // u
        tbl[ntbl++] = mk(7'h23, 1, 6'b000000, 6'b000000, 1'b1, 1'b0);  // # unsupported
        tbl[ntbl++] = mk(7'h33, 2, 6'b111100, 6'b001001, 1'b0, 1'b0);  // 3
        tbl[ntbl++] = mk(7'h30, 1, 6'b011010, 6'b000000, 1'b0, 1'b0);  // 0
        tbl[ntbl++] = mk(7'h25, 1, 6'b000000, 6'b000000, 1'b1, 1'b0);  // % keeps number mode
        tbl[ntbl++] = mk(7'h39, 1, 6'b001010, 6'b000000, 1'b0, 1'b0);  // 9
        tbl[ntbl++] = mk(7'h20, 1, 6'b000000, 6'b000000, 1'b0, 1'b0);  // space
        tbl[ntbl++] = mk(7'h32, 2, 6'b111100, 6'b000011, 1'b0, 1'b1);  // 2 with input noise

        repeat (2) @(negedge clk);
        checkOutput("reset_state", obs, 10'b1_0_0_0_000000);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_idle", obs, 10'b1_0_0_0_000000);

        for (int i = 0; i < ntbl; i++) begin
            applyStimulus(tbl[i], i);
        end

        // '8' lands in number mode, then reset mid-cell must clear number mode too.
        in_valid = 1'b1;
        in_char  = 7'h38;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("cell_8_first", obs, 10'b0_0_0_1_010011);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset_now", obs, 10'b1_0_0_0_000000);
        #3 checkOutput("reset_held", obs, 10'b1_0_0_0_000000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(mk(7'h34, 2, 6'b111100, 6'b011001, 1'b0, 1'b0), 99);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
